bbox_crop_scaler: RTL and testbench

//  Downstream of the bounding-box stage: on start, reads the RGB pixels inside the latched box
//  [x_min..x_max]x[y_min..y_max] from image memory, nearest-neighbour scales them to OUT_W x OUT_H,

---
 rtl/crop_pkg.sv | 32 +++
 rtl/coord_map.sv | 19 +
 rtl/bbox_crop_scaler.sv | 167 ++++++++++++++++
 tb/tb_bbox_crop_scaler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/crop_pkg.sv
// rtl/crop_pkg.sv - shared state encoding, channel offsets and pixel helpers for bbox_crop_scaler
package crop_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        RD_R,
        RD_G,
        RD_B,
        CAP_B,
        WRITE,
        FILL,
        DONE
    } state_t;

    localparam logic [31:0] CH_R = 32'd0;
    localparam logic [31:0] CH_G = 32'd1;
    localparam logic [31:0] CH_B = 32'd2;

    // Memory words are 16 bits wide; anything above 8-bit range clips to white.
    function automatic logic [7:0] sat8(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    // Luma approximation (R + 2G + B) / 4; the 10-bit sum cannot overflow.
    function automatic logic [7:0] grey8(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/coord_map.sv
// rtl/coord_map.sv - nearest-neighbour map of an output index onto a source coordinate
module coord_map #(
    parameter int unsigned OUT_N = 28
) (
    input  logic [10:0] min,
    input  logic [11:0] span,
    input  logic [15:0] idx,
    output logic [10:0] src
);

    logic [31:0] prod;

    // src = min + floor(idx * span / OUT_N); idx < OUT_N keeps src <= min + span - 1
    always_comb begin
        prod = {16'd0, idx} * {20'd0, span};
        src  = min + 11'(prod / OUT_N);
    end

endmodule

// File: rtl/bbox_crop_scaler.sv
// rtl/bbox_crop_scaler.sv - crop latched box from RGB memory, scale to OUT_W x OUT_H grey; option BBOX_CROP_BINARIZE_EN
module bbox_crop_scaler
    import crop_pkg::*;
#(
    parameter int unsigned WIDTH  = 100,
    parameter int unsigned HEIGHT = 100,
    parameter int unsigned OUT_W  = 28,
    parameter int unsigned OUT_H  = 28,
    parameter int unsigned THRESH = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    input  logic [10:0] x_min,
    input  logic [10:0] x_max,
    input  logic [10:0] y_min,
    input  logic [10:0] y_max,
    output logic [31:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data
);

    localparam logic [31:0] ROW_STRIDE = 32'(HEIGHT * 3);
    localparam logic [10:0] X_LAST     = 11'(WIDTH - 1);
    localparam logic [10:0] Y_LAST     = 11'(HEIGHT - 1);
    localparam logic [15:0] OX_LAST    = 16'(OUT_W - 1);
    localparam logic [15:0] OY_LAST    = 16'(OUT_H - 1);
    localparam logic [15:0] OUT_W16    = 16'(OUT_W);

`ifdef BBOX_CROP_BINARIZE_EN
    localparam logic [7:0]  FILL_VAL   = 8'h00;
`else
    localparam logic [7:0]  FILL_VAL   = 8'hFF;
`endif

    state_t      state, state_nxt;
    logic [10:0] bx_min, bx_max, by_min, by_max;
    logic [11:0] bw, bh;
    logic [15:0] ox, oy;
    logic [7:0]  r_q, g_q, b_q;
    logic [31:0] rd_addr_q;
    logic [15:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [10:0] sx, sy, sx_c, sy_c;
    logic [31:0] base;
    logic [7:0]  pix_val;
    logic        empty_box, last_px;

    coord_map #(.OUT_N(OUT_W)) u_map_x (.min(bx_min), .span(bw), .idx(ox), .src(sx));
    coord_map #(.OUT_N(OUT_H)) u_map_y (.min(by_min), .span(bh), .idx(oy), .src(sy));

    assign empty_box = (bx_min > bx_max) || (by_min > by_max);
    assign last_px   = (ox == OX_LAST) && (oy == OY_LAST);

    // Source pixel base address; a box reaching past the image edge is clamped to stay in memory.
    always_comb begin
        sx_c    = (sx > X_LAST) ? X_LAST : sx;
        sy_c    = (sy > Y_LAST) ? Y_LAST : sy;
        base    = {21'd0, sx_c} * ROW_STRIDE + {21'd0, sy_c} * 32'd3;
`ifdef BBOX_CROP_BINARIZE_EN
        pix_val = (grey8(r_q, g_q, b_q) < 8'(THRESH)) ? 8'hFF : 8'h00;
`else
        pix_val = grey8(r_q, g_q, b_q);
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and output drive; outputs fall back to held copies outside active cycles.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        rd_addr   = rd_addr_q;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: state_nxt = empty_box ? FILL : RD_R;
            RD_R: begin
                rd_addr   = base + CH_R;
                state_nxt = RD_G;
            end
            RD_G: begin
                rd_addr   = base + CH_G;
                state_nxt = RD_B;
            end
            RD_B: begin
                rd_addr   = base + CH_B;
                state_nxt = CAP_B;
            end
            CAP_B: state_nxt = WRITE;
            WRITE: begin
                wr_en     = 1'b1;
                wr_addr   = oy * OUT_W16 + ox;
                wr_data   = pix_val;
                state_nxt = last_px ? DONE : RD_R;
            end
            FILL: begin
                wr_en     = 1'b1;
                wr_addr   = oy * OUT_W16 + ox;
                wr_data   = FILL_VAL;
                state_nxt = last_px ? DONE : FILL;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = SETUP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Box latch, span setup, channel capture, raster counters and output hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx_min    <= '0;
            bx_max    <= '0;
            by_min    <= '0;
            by_max    <= '0;
            bw        <= '0;
            bh        <= '0;
            ox        <= '0;
            oy        <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if ((state == IDLE || state == DONE) && start) begin
                bx_min <= x_min;
                bx_max <= x_max;
                by_min <= y_min;
                by_max <= y_max;
            end
            if (state == SETUP) begin
                bw <= {1'b0, bx_max} - {1'b0, bx_min} + 12'd1;
                bh <= {1'b0, by_max} - {1'b0, by_min} + 12'd1;
                ox <= '0;
                oy <= '0;
            end
            if (state == RD_G)  r_q <= sat8(rd_data);
            if (state == RD_B)  g_q <= sat8(rd_data);
            if (state == CAP_B) b_q <= sat8(rd_data);
            if (state == RD_R || state == RD_G || state == RD_B) rd_addr_q <= rd_addr;
            if (wr_en) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
                if (ox == OX_LAST) begin
                    ox <= '0;
                    oy <= oy + 16'd1;
                end else begin
                    ox <= ox + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_crop_scaler.sv
// tb/tb_bbox_crop_scaler.sv - self-checking bench for bbox_crop_scaler against an arithmetic reference model
module tb_bbox_crop_scaler;

    localparam int W = 100, H = 100, OW = 28, OH = 28, NPIX = OW * OH, MEMN = W * H * 3, THR = 250;

    logic        clk, rst, start, done, wr_en;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic [31:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    logic [15:0] mem [0:MEMN-1];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [31:0] rd_hist[$];

    int n_checks = 0;
    int n_fail   = 0;

    bbox_crop_scaler #(.WIDTH(W), .HEIGHT(H), .OUT_W(OW), .OUT_H(OH), .THRESH(THR)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= (rd_addr < 32'(MEMN)) ? mem[rd_addr[14:0]] : 16'h0000;

    always @(negedge clk) if (wr_en === 1'b1) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int chan(int a);
        return (mem[a] > 16'd255) ? 255 : int'(mem[a]);
    endfunction

    function automatic int ref_pix(int xmn, int xmx, int ymn, int ymx, int ox, int oy);
        int sx, sy, a, g;
        if (xmn > xmx || ymn > ymx) begin
`ifdef BBOX_CROP_BINARIZE_EN
            return 0;
`else
            return 255;
`endif
        end
        sx = xmn + (ox * (xmx - xmn + 1)) / OW;
        sy = ymn + (oy * (ymx - ymn + 1)) / OH;
        a  = sx * H * 3 + sy * 3;
        g  = (chan(a) + 2 * chan(a + 1) + chan(a + 2)) / 4;
`ifdef BBOX_CROP_BINARIZE_EN
        return (g < THR) ? 255 : 0;
`else
        return g;
`endif
    endfunction

    task automatic run_frame(input int xmn, input int xmx, input int ymn, input int ymx, input int poke_at,
                             output int cyc, output bit moved);
        logic [31:0] rd0;
        wa_q.delete();
        wd_q.delete();
        rd_hist.delete();
        moved = 0;
        @(negedge clk);
        x_min = 11'(xmn); x_max = 11'(xmx); y_min = 11'(ymn); y_max = 11'(ymx);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        x_min = 11'($urandom_range(0, 99)); x_max = 11'($urandom_range(0, 99));
        y_min = 11'($urandom_range(0, 99)); y_max = 11'($urandom_range(0, 99));
        rd0 = rd_addr;
        while (1) begin
            rd_hist.push_back(rd_addr);
            if (rd_addr !== rd0) moved = 1;
            if (done === 1'b1 || cyc >= 6000) break;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == poke_at) ? 1'b1 : 1'b0;
            if (cyc == poke_at) begin
                x_min = 11'd0; x_max = 11'd3; y_min = 11'd0; y_max = 11'd3;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int xmn, input int xmx, input int ymn, input int ymx);
        check({tag, "_nwr"}, wa_q.size(), NPIX);
        check({tag, "_done"}, done, 1);
        check({tag, "_wren_idle"}, wr_en, 0);
        check({tag, "_wr_addr_hold"}, wr_addr, NPIX - 1);
        for (int i = 0; i < NPIX && i < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wd_q[i], ref_pix(xmn, xmx, ymn, ymx, i % OW, i / OW));
        end
    endtask

    initial begin
        int  cyc, sz, bx0, bx1, by0, by1;
        bit  moved;
        for (int i = 0; i < MEMN; i++) mem[i] = 16'($urandom_range(0, 511));
        rst = 1'b1; start = 1'b0;
        x_min = '0; x_max = '0; y_min = '0; y_max = '0;
        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;

        // Full image, 100x100 -> 28x28
        run_frame(0, 99, 0, 99, -1, cyc, moved);
        check("full_rd0", rd_hist[1], 0);
        check("full_rd1", rd_hist[2], 1);
        check("full_rd2", rd_hist[3], 2);
        check("full_px27_rd", rd_hist[1 + 5 * 27], 28800);
        check("full_cycles", cyc, NPIX * 5 + 2);
        check_frame("full", 0, 99, 0, 99);

        // 1:1 crop
        run_frame(10, 37, 20, 47, -1, cyc, moved);
        check("one_rd0", rd_hist[1], 3060);
        check_frame("one", 10, 37, 20, 47);

        // Single-pixel box with hand-picked channel values
        mem[15150] = 16'd10; mem[15151] = 16'd20; mem[15152] = 16'd30;
        run_frame(50, 50, 50, 50, -1, cyc, moved);
        check("single_cycles", cyc, NPIX * 5 + 2);
`ifdef BBOX_CROP_BINARIZE_EN
        check("grey20_bin", wd_q[0], 8'hFF);
`else
        check("grey20", wd_q[0], 20);
`endif
        check_frame("single", 50, 50, 50, 50);
        mem[15150] = 16'h1FF; mem[15151] = 16'h1FF; mem[15152] = 16'h1FF;
        run_frame(50, 50, 50, 50, -1, cyc, moved);
`ifdef BBOX_CROP_BINARIZE_EN
        check("grey_sat_bin", wd_q[0], 8'h00);
`else
        check("grey_sat", wd_q[0], 255);
`endif
        check_frame("sat", 50, 50, 50, 50);

        // Empty box
        run_frame(99, 0, 0, 99, -1, cyc, moved);
        check("fill_cycles", cyc, NPIX + 2);
        check("fill_rd_static", moved, 0);
        check_frame("fill", 99, 0, 0, 99);

        // Random non-empty boxes
        for (int k = 0; k < 3; k++) begin
            bx0 = $urandom_range(0, 99); bx1 = $urandom_range(bx0, 99);
            by0 = $urandom_range(0, 99); by1 = $urandom_range(by0, 99);
            run_frame(bx0, bx1, by0, by1, -1, cyc, moved);
            check($sformatf("rand%0d_cycles", k), cyc, NPIX * 5 + 2);
            check_frame($sformatf("rand%0d", k), bx0, bx1, by0, by1);
        end

        // Start pulsed while busy is ignored
        run_frame(5, 60, 30, 90, 200, cyc, moved);
        check("busy_cycles", cyc, NPIX * 5 + 2);
        check_frame("busy", 5, 60, 30, 90);

        // Reset mid-frame after 100 writes
        wa_q.delete();
        wd_q.delete();
        @(negedge clk);
        x_min = 11'd0; x_max = 11'd99; y_min = 11'd0; y_max = 11'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (wa_q.size() < 100 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reached100", wa_q.size(), 100);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        @(negedge clk);
        rst = 1'b0;
        sz = wa_q.size();
        repeat (100) @(negedge clk);
        check("mid_no_writes", wa_q.size(), sz);
        check("mid_done_low", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
